// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_e    : sequencer states (RUN, MEM_WAIT)
//   ctrl_t     : bundle of the six pipeline control outputs
//   CTRL_*     : canonical control patterns (idle, branch flush, hold, load-use)
package hazard_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_flush: 1'b0, pipe_hold: 1'b0};

    // Branch redirect: PC loads the target while the wrong-path front end is squashed.
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, exmem_flush: 1'b1, pipe_hold: 1'b0};

    localparam ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_flush: 1'b0, pipe_hold: 1'b1};

    localparam ctrl_t CTRL_LU = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                  idex_bubble: 1'b1, exmem_flush: 1'b0, pipe_hold: 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard statistics.
//   clk     : clock
//   reset   : asynchronous active-high reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves taken branches,
// data-memory waits and load-use hazards (in that priority) into Mealy control
// strobes, and keeps saturating statistics plus a sticky memory-wait watchdog.
//   clk, reset          : clock, asynchronous active-high reset
//   IFID_rs1/rs2        : source registers of the instruction in ID
//   IFID_uses_rs2       : ID instruction actually reads rs2
//   IDEX_MemRead/rd     : instruction in EX is a load, and its destination
//   branch_taken        : one-cycle strobe from EX/MEM
//   dmem_req/dmem_ready : MEM-stage access issued / completed this cycle
//   PC_Write ... pipe_hold : pipeline control (same-cycle)
//   mem_timeout         : sticky, set after MAX_WAIT unfinished wait cycles
//   stall_cycles        : cycles with PC_Write=0 (saturating)
//   flush_events        : cycles with IFID_Flush=1 (saturating)
//
// state    | meaning
// RUN      | normal flow; branch, new memory wait or load-use handled here
// MEM_WAIT | data access outstanding; whole pipe frozen, branches deferred
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IFID_rs1,
    input  logic [REG_W-1:0] IFID_rs2,
    input  logic             IFID_uses_rs2,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Flush,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic              pend_br_q, pend_br_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              wait_inc;
    logic              wait_clr;
    logic              load_use;
    ctrl_t             ctrl;

    // A load into x0 never creates a dependency.
    assign load_use = IDEX_MemRead && (IDEX_rd != '0) &&
                      ((IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));

    always_comb begin
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        pend_br_d = pend_br_q;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    // Redirect now; a coincident memory wait still freezes from next cycle.
                    ctrl = CTRL_BRANCH;
                    if (dmem_req && !dmem_ready) begin
                        state_d = MEM_WAIT;
                    end
                end else if (dmem_req && !dmem_ready) begin
                    ctrl    = CTRL_HOLD;
                    state_d = MEM_WAIT;
                end else if (load_use) begin
                    ctrl = CTRL_LU;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    ctrl     = CTRL_HOLD;
                    wait_inc = 1'b1;
                    if (branch_taken) begin
                        pend_br_d = 1'b1;
                    end
                end else begin
                    state_d  = RUN;
                    wait_clr = 1'b1;
                    if (pend_br_q || branch_taken) begin
                        ctrl      = CTRL_BRANCH;
                        pend_br_d = 1'b0;
                    end else if (load_use) begin
                        ctrl = CTRL_LU;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (wait_clr) begin
            wait_cnt_d = '0;
        end else if (wait_inc) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q >= WAIT_LAST) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pend_br_q     <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_br_q     <= pend_br_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (!ctrl.pc_write),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (ctrl.ifid_flush),
        .count_o (flush_events)
    );

    assign PC_Write    = ctrl.pc_write;
    assign IFID_Write  = ctrl.ifid_write;
    assign IFID_Flush  = ctrl.ifid_flush;
    assign IDEX_Bubble = ctrl.idex_bubble;
    assign EXMEM_Flush = ctrl.exmem_flush;
    assign pipe_hold   = ctrl.pipe_hold;
    assign mem_timeout = mem_timeout_q;

endmodule
